// File: rtl/image_pass_sequencer_pkg.sv
// Shared definitions for the frame-memory pass sequencer: FSM encoding,
// index widths and the canonical pass numbering used by the frame controller.
package image_pass_sequencer_pkg;

   localparam int PASS_IDX_WIDTH   = 4;
   // One extra bit so "last pass + 1" is representable when 16 passes exist.
   localparam int SCAN_IDX_WIDTH   = PASS_IDX_WIDTH + 1;
   localparam int SETTLE_CNT_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SELECT    = 3'd1,
      WAIT_DONE = 3'd2,
      SETTLE    = 3'd3,
      FINISH    = 3'd4
   } seq_state_t;

   localparam logic [PASS_IDX_WIDTH-1:0] PASS_X_FILL = 4'd0;
   localparam logic [PASS_IDX_WIDTH-1:0] PASS_Y_FILL = 4'd1;
   localparam logic [PASS_IDX_WIDTH-1:0] PASS_EDGE_H = 4'd2;
   localparam logic [PASS_IDX_WIDTH-1:0] PASS_EDGE_V = 4'd3;

endpackage

// File: rtl/image_pass_sequencer_pass_priority_select.sv
// Combinational finder: lowest set mask bit whose index is at or above start_idx.
module pass_priority_select
   import image_pass_sequencer_pkg::*;
#(
   parameter int NUM_PASSES = 4
) (
   input  logic [NUM_PASSES-1:0]     mask,
   input  logic [SCAN_IDX_WIDTH-1:0] start_idx,
   output logic                      found,
   output logic [PASS_IDX_WIDTH-1:0] index
);

   // Descending walk so the lowest qualifying bit is the last one written.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = NUM_PASSES - 1; i >= 0; i--) begin
         if (mask[i] && (SCAN_IDX_WIDTH'(i) >= start_idx)) begin
            found = 1'b1;
            index = PASS_IDX_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/image_pass_sequencer.sv
// Initiator of the pass enable/done handshake: runs the masked passes one at a
// time, with a watchdog per pass and an all-low settle gap between passes.
module image_pass_sequencer
   import image_pass_sequencer_pkg::*;
#(
   parameter int NUM_PASSES     = 4,
   parameter int TIMEOUT_WIDTH  = 20,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SETTLE_CYCLES  = 2
) (
   input  logic                      clk_div_by_two,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [NUM_PASSES-1:0]     pass_mask,
   input  logic [NUM_PASSES-1:0]     pass_done,
   output logic [NUM_PASSES-1:0]     pass_enable,
   output logic                      busy,
   output logic                      sequence_done,
   output logic                      error,
   output logic [PASS_IDX_WIDTH-1:0] error_pass,
   output logic [PASS_IDX_WIDTH-1:0] current_pass
);

   seq_state_t                  state, state_nxt;
   logic [NUM_PASSES-1:0]       mask_q, mask_nxt;
   logic [SCAN_IDX_WIDTH-1:0]   scan_idx, scan_nxt;
   logic [TIMEOUT_WIDTH-1:0]    tcount, tcount_nxt;
   logic [SETTLE_CNT_WIDTH-1:0] settle_cnt, settle_nxt;
   logic [NUM_PASSES-1:0]       enable_nxt;
   logic                        busy_nxt, done_nxt, error_nxt;
   logic [PASS_IDX_WIDTH-1:0]   error_pass_nxt, current_nxt;

   logic                        sel_found;
   logic [PASS_IDX_WIDTH-1:0]   sel_idx;
   logic [NUM_PASSES-1:0]       sel_onehot;
   logic                        cur_done;

   pass_priority_select #(
      .NUM_PASSES (NUM_PASSES)
   ) u_select (
      .mask      (mask_q),
      .start_idx (scan_idx),
      .found     (sel_found),
      .index     (sel_idx)
   );

   // Only the enabled pass's done bit matters; stray done levels are ignored.
   always_comb begin
      sel_onehot = '0;
      cur_done   = 1'b0;
      for (int i = 0; i < NUM_PASSES; i++) begin
         if (sel_idx == PASS_IDX_WIDTH'(i))      sel_onehot[i] = 1'b1;
         if (current_pass == PASS_IDX_WIDTH'(i)) cur_done      = pass_done[i];
      end
   end

   // NOTE: every signal gets its hold value before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt      = state;
      mask_nxt       = mask_q;
      scan_nxt       = scan_idx;
      tcount_nxt     = tcount;
      settle_nxt     = settle_cnt;
      enable_nxt     = pass_enable;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      error_nxt      = error;
      error_pass_nxt = error_pass;
      current_nxt    = current_pass;

      case (state)
         IDLE: begin
            if (start) begin
               mask_nxt       = pass_mask;
               busy_nxt       = 1'b1;
               error_nxt      = 1'b0;
               error_pass_nxt = '0;
               scan_nxt       = '0;
               state_nxt      = SELECT;
            end
         end
         SELECT: begin
            if (sel_found) begin
               enable_nxt  = sel_onehot;
               current_nxt = sel_idx;
               tcount_nxt  = '0;
               state_nxt   = WAIT_DONE;
            end else begin
               done_nxt    = 1'b1;
               busy_nxt    = 1'b0;
               current_nxt = '0;
               state_nxt   = FINISH;
            end
         end
         WAIT_DONE: begin
            if (cur_done) begin
               enable_nxt = '0;
               scan_nxt   = SCAN_IDX_WIDTH'(current_pass) + SCAN_IDX_WIDTH'(1);
               settle_nxt = '0;
               state_nxt  = SETTLE;
            end else if (tcount == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               // Abort: dropping the remaining mask bits makes SELECT fall to FINISH.
               enable_nxt     = '0;
               error_nxt      = 1'b1;
               error_pass_nxt = current_pass;
               mask_nxt       = '0;
               settle_nxt     = '0;
               state_nxt      = SETTLE;
            end else if (tcount != '1) begin
               tcount_nxt = tcount + 1'b1;
            end
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
               state_nxt = SELECT;
            end else begin
               settle_nxt = settle_cnt + 1'b1;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_div_by_two) begin
      if (!rst_n) begin
         state         <= IDLE;
         mask_q        <= '0;
         scan_idx      <= '0;
         tcount        <= '0;
         settle_cnt    <= '0;
         pass_enable   <= '0;
         busy          <= 1'b0;
         sequence_done <= 1'b0;
         error         <= 1'b0;
         error_pass    <= '0;
         current_pass  <= '0;
      end else begin
         state         <= state_nxt;
         mask_q        <= mask_nxt;
         scan_idx      <= scan_nxt;
         tcount        <= tcount_nxt;
         settle_cnt    <= settle_nxt;
         pass_enable   <= enable_nxt;
         busy          <= busy_nxt;
         sequence_done <= done_nxt;
         error         <= error_nxt;
         error_pass    <= error_pass_nxt;
         current_pass  <= current_nxt;
      end
   end

endmodule

// File: tb/tb_image_pass_sequencer.sv
// Self-checking bench for image_pass_sequencer: pass responders, a timeline
// model of each sequence, directed corner cases and randomized masks/latencies.
module tb_image_pass_sequencer;

   localparam int NP = 4;
   localparam int TO = 16;
   localparam int ST = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [NP-1:0] pass_mask = '0;
   logic [NP-1:0] resp_done = '0;
   logic [NP-1:0] stray = '0;
   logic [NP-1:0] pass_done;
   logic [NP-1:0] pass_enable;
   logic          busy, sequence_done, error;
   logic [3:0]    error_pass, current_pass;

   assign pass_done = resp_done | stray;
   always #5 clk = ~clk;

   image_pass_sequencer #(
      .NUM_PASSES     (NP),
      .TIMEOUT_WIDTH  (20),
      .TIMEOUT_CYCLES (TO),
      .SETTLE_CYCLES  (ST)
   ) dut (
      .clk_div_by_two (clk),
      .rst_n          (rst_n),
      .start          (start),
      .pass_mask      (pass_mask),
      .pass_done      (pass_done),
      .pass_enable    (pass_enable),
      .busy           (busy),
      .sequence_done  (sequence_done),
      .error          (error),
      .error_pass     (error_pass),
      .current_pass   (current_pass)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", what, got, exp);
      end
   endtask

   // Pass responders: done latency in cycles after enable rises, 0 = never.
   int cfg_dly[NP];
   int age[NP];

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
         if (pass_enable[i] === 1'b1) age[i]++;
         else                         age[i] = 0;
         resp_done[i] = (cfg_dly[i] != 0) && (age[i] >= cfg_dly[i]);
      end
   end

   function automatic int low_idx(input logic [NP-1:0] v);
      low_idx = 0;
      for (int i = NP - 1; i >= 0; i--) if (v[i]) low_idx = i;
   endfunction

   // Monitor: records each enable run and counts invariant violations.
   bit            mon_on = 1'b0;
   bit            seen_run = 1'b0;
   int            inv_bad = 0, gap_bad = 0, sd_pulses = 0, zero_run = 0;
   logic [NP-1:0] prev_en = '0;
   int            run_pass[$];
   int            run_len[$];

   initial forever begin
      @(negedge clk);
      if (mon_on) begin
         if ($countones(pass_enable) > 1) inv_bad++;
         if (sequence_done === 1'b1) begin
            sd_pulses++;
            if (busy !== 1'b0) inv_bad++;
         end
         if (pass_enable != '0) begin
            if (current_pass !== 4'(low_idx(pass_enable))) inv_bad++;
            if (prev_en == '0) begin
               if (seen_run && zero_run < ST) gap_bad++;
               run_pass.push_back(low_idx(pass_enable));
               run_len.push_back(1);
               seen_run = 1'b1;
            end else if (pass_enable != prev_en) begin
               gap_bad++;
            end else begin
               run_len[run_len.size()-1] += 1;
            end
            zero_run = 0;
         end else begin
            zero_run++;
         end
         prev_en = pass_enable;
      end
   end

   // Timeline model: each run pass costs SELECT + enable time + settle gap,
   // then a final SELECT and FINISH; a hanging pass ends the sequence.
   function automatic int exp_len(input int p);
      exp_len = (cfg_dly[p] == 0) ? TO : cfg_dly[p];
   endfunction

   task automatic model(input logic [NP-1:0] mask, output logic [NP-1:0] en,
                        output logic err, output logic [3:0] ep, output int at);
      en = '0; err = 1'b0; ep = '0; at = 2;
      for (int p = 0; p < NP; p++) begin
         if (mask[p] && !err) begin
            en[p] = 1'b1;
            at += 1 + exp_len(p) + ST;
            if (cfg_dly[p] == 0) begin
               err = 1'b1;
               ep  = 4'(p);
            end
         end
      end
   endtask

   // Called at a negedge with start low; runs one sequence and checks it.
   task automatic run_seq(input string name, input logic [NP-1:0] mask,
                          input logic [NP-1:0] exp_en, input logic exp_err,
                          input logic [3:0] exp_ep, input int exp_at, input bit disturb);
      int n;
      int k;
      run_pass.delete();
      run_len.delete();
      sd_pulses = 0;
      pass_mask = mask;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check({name, "/accept"}, 32'({busy, error, error_pass}), 32'({1'b1, 1'b0, 4'd0}));
      while (sequence_done !== 1'b1 && n < 400) begin
         if (disturb) begin
            if (n == 2) begin start = 1'b1; stray = 4'b0100; end
            if (n == 3) start = 1'b0;
            if (n == 4) stray = '0;
         end
         @(negedge clk);
         n++;
      end
      check({name, "/done_at"}, n, exp_at);
      check({name, "/err"}, 32'({error, error_pass}), 32'({exp_err, exp_ep}));
      check({name, "/done_state"}, 32'({busy, current_pass, pass_enable}), 0);
      k = 0;
      for (int p = 0; p < NP; p++) begin
         if (exp_en[p]) begin
            if (k < run_pass.size()) begin
               check({name, "/order"}, run_pass[k], p);
               check({name, "/len"}, run_len[k], exp_len(p));
            end
            k++;
         end
      end
      check({name, "/runs"}, run_pass.size(), $countones(exp_en));
      repeat (4) @(negedge clk);
      check({name, "/pulses"}, sd_pulses, 1);
      check({name, "/idle"}, 32'({busy, error, error_pass}), 32'({1'b0, exp_err, exp_ep}));
      check({name, "/onehot"}, inv_bad, 0);
      check({name, "/gap"}, gap_bad, 0);
   endtask

   typedef struct {
      string         name;
      logic [NP-1:0] mask;
      logic [NP-1:0] hang;
      int            delay;
      logic [NP-1:0] exp_en;
      logic          exp_err;
      logic [3:0]    exp_ep;
      int            exp_at;
   } vec_t;

   vec_t vecs[6];
   logic [1:0] fin_exp[5];

   initial begin
      logic [NP-1:0] m_en;
      logic          m_err;
      logic [3:0]    m_ep;
      int            m_at;
      int            n;

      vecs[0] = '{"normal",  4'b1011, 4'b0000, 5, 4'b1011, 1'b0, 4'd0, 26};
      vecs[1] = '{"timeout", 4'b0111, 4'b0010, 5, 4'b0011, 1'b1, 4'd1, 29};
      vecs[2] = '{"empty",   4'b0000, 4'b0000, 5, 4'b0000, 1'b0, 4'd0, 2};
      vecs[3] = '{"single3", 4'b1000, 4'b0000, 1, 4'b1000, 1'b0, 4'd0, 6};
      vecs[4] = '{"hang0",   4'b1001, 4'b0001, 3, 4'b0001, 1'b1, 4'd0, 21};
      vecs[5] = '{"all_d2",  4'b1111, 4'b0000, 2, 4'b1111, 1'b0, 4'd0, 22};
      // {sequence_done, busy} with start held high across an empty sequence
      fin_exp = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

      // Reset held with start asserted: everything stays at reset values.
      start = 1'b1;
      pass_mask = 4'hF;
      repeat (3) begin
         @(negedge clk);
         check("reset_outs", 32'({pass_enable, busy, sequence_done, error, error_pass, current_pass}), 0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);

      // start ignored in FINISH, accepted in the following IDLE cycle.
      pass_mask = '0;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("finish_window", 32'({sequence_done, busy}), 32'(fin_exp[i]));
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         for (int p = 0; p < NP; p++) cfg_dly[p] = vecs[v].hang[p] ? 0 : vecs[v].delay;
         run_seq(vecs[v].name, vecs[v].mask, vecs[v].exp_en, vecs[v].exp_err,
                 vecs[v].exp_ep, vecs[v].exp_at, 1'b0);
      end

      // Second start and a stray done on pass 2 while pass 0 is enabled.
      for (int p = 0; p < NP; p++) cfg_dly[p] = 5;
      run_seq("busy_start", 4'b0111, 4'b0111, 1'b0, 4'd0, 26, 1'b1);

      // Reset while pass 1 is enabled, then a clean restart from pass 0.
      pass_mask = 4'hF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (pass_enable[1] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("midrst_reach", 32'(pass_enable), 32'(4'b0010));
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_outs", 32'({pass_enable, busy, sequence_done, error, current_pass}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_seq("restart", 4'hF, 4'hF, 1'b0, 4'd0, 34, 1'b0);

      for (int it = 0; it < 20; it++) begin
         for (int p = 0; p < NP; p++)
            cfg_dly[p] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
         pass_mask = 4'($urandom);
         model(pass_mask, m_en, m_err, m_ep, m_at);
         run_seq("random", pass_mask, m_en, m_err, m_ep, m_at, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

endmodule
